cmd_decoder: RTL and testbench

CMD_DECODER -- requirements
Module: cmd_decoder

---
 rtl/cmd_decoder.sv | 161 ++++++++++++++++
 tb/tb_cmd_decoder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_decoder.sv
// Key-code command decoder: turns a held/pressed 4-bit code into character display settings.
// Latency: one cycle from the sampling edge of a fire to the registered effect and cmdAck pulse.
// Backpressure: none; one command per cycle, auto-repeat paces held codes 4..C.
module cmd_decoder #(
  parameter int CH_BITS    = 3,
  parameter int SIZE_MAX   = 8,
  parameter int REPEAT_DLY = 16,
  parameter int REPEAT_PER = 4,
  parameter int FLASH_DIV  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inValid,
  input  logic [3:0]           inCode,
  output logic [2:0]           userNum,
  output logic [3:0]           charSize,
  output logic [3*CH_BITS-1:0] charRGB,
  output logic [3*CH_BITS-1:0] bgRGB,
  output logic [3:0]           charOffset,
  output logic                 flashClk,
  output logic                 cmdAck
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(FLASH_DIV + 1);
  localparam int RGB_W   = 3 * CH_BITS;

  localparam logic [CNT_W-1:0]   DLY_LOAD = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0]   PER_LOAD = CNT_W'(REPEAT_PER - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FLASH_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE  = DIV_W'(1);
  localparam logic [CH_BITS-1:0] CH_ONE   = CH_BITS'(1);
  localparam logic [3:0]         SIZE_TOP = 4'(SIZE_MAX);

  // Registered state
  logic             prev_vld_q;
  logic [3:0]       prev_code_q;
  logic [CNT_W-1:0] rep_cnt_q;
  logic [2:0]       user_q,   user_d;
  logic [3:0]       size_q,   size_d;
  logic [RGB_W-1:0] fg_q,     fg_d;
  logic [RGB_W-1:0] bg_q,     bg_d;
  logic [3:0]       off_q,    off_d;
  logic             tgt_q,    tgt_d;
  logic             en_q,     en_d;
  logic             ack_q;
  logic             flash_q;
  logic [DIV_W-1:0] div_q;

  // Fire detection: a fresh press/change, or a repeat tick on a held repeatable code
  logic new_press, held_same, rep_code, rep_tick, fire;
  assign new_press = inValid && (!prev_vld_q || (inCode != prev_code_q));
  assign held_same = inValid && prev_vld_q && (inCode == prev_code_q);
  assign rep_code  = (inCode >= 4'h4) && (inCode <= 4'hC);
  assign rep_tick  = held_same && rep_code && (rep_cnt_q == '0);
  assign fire      = new_press || rep_tick;

  // Next-state of the display settings for the command executing this cycle
  always_comb begin
    logic [RGB_W-1:0] sel;
    user_d = user_q;
    size_d = size_q;
    fg_d   = fg_q;
    bg_d   = bg_q;
    off_d  = '0;
    tgt_d  = tgt_q;
    en_d   = en_q;
    sel    = tgt_q ? bg_q : fg_q;
    if (fire) begin
      case (inCode)
        4'h0, 4'h1, 4'h2, 4'h3: user_d = {1'b0, inCode[1:0]};
        4'h4, 4'h5, 4'h6: begin
          // channel 0 (R) sits in the top field
          for (int ch = 0; ch < 3; ch++) begin
            if (inCode == 4'(4 + ch))
              sel[(2-ch)*CH_BITS +: CH_BITS] = sel[(2-ch)*CH_BITS +: CH_BITS] + CH_ONE;
          end
          if (tgt_q) bg_d = sel;
          else       fg_d = sel;
        end
        4'h7, 4'h8, 4'h9, 4'hA: off_d = 4'b0001 << (inCode - 4'h7);
        4'hB: if (size_q < SIZE_TOP) size_d = size_q + 4'd1;
        4'hC: if (size_q > 4'd1)     size_d = size_q - 4'd1;
        4'hD: tgt_d = ~tgt_q;
        4'hE: en_d  = ~en_q;
        4'hF: begin
          fg_d = '1;
          bg_d = '0;
        end
        default: ;
      endcase
    end
  end

  // Settings registers, previous-input tracking and the ack pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_vld_q  <= 1'b0;
      prev_code_q <= 4'h0;
      user_q      <= 3'b100;
      size_q      <= 4'd1;
      fg_q        <= '1;
      bg_q        <= '0;
      off_q       <= 4'h0;
      tgt_q       <= 1'b0;
      en_q        <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      prev_vld_q  <= inValid;
      prev_code_q <= inCode;
      user_q      <= user_d;
      size_q      <= size_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      off_q       <= off_d;
      tgt_q       <= tgt_d;
      en_q        <= en_d;
      ack_q       <= fire;
    end
  end

  // Hold counter: counts down to the next auto-repeat; zero means a repeat is due
  always_ff @(posedge clock) begin
    if (reset || !inValid) begin
      rep_cnt_q <= '0;
    end else if (new_press) begin
      rep_cnt_q <= DLY_LOAD;
    end else if (rep_tick) begin
      rep_cnt_q <= PER_LOAD;
    end else if (rep_cnt_q != '0) begin
      rep_cnt_q <= rep_cnt_q - CNT_ONE;
    end
  end

  // Flash divider: uses next-cycle enable so disabling restores flashClk immediately
  always_ff @(posedge clock) begin
    if (reset || !en_d) begin
      flash_q <= 1'b1;
      div_q   <= '0;
    end else if (!en_q) begin
      flash_q <= 1'b1;
      div_q   <= '0;
    end else if (div_q == DIV_LAST) begin
      flash_q <= ~flash_q;
      div_q   <= '0;
    end else begin
      div_q   <= div_q + DIV_ONE;
    end
  end

  assign userNum    = user_q;
  assign charSize   = size_q;
  assign charRGB    = fg_q;
  assign bgRGB      = bg_q;
  assign charOffset = off_q;
  assign flashClk   = flash_q;
  assign cmdAck     = ack_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder with default parameters: scoreboard of full output vectors
// built from a behavioural model, plus scenario-specific expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_cmd_decoder;
  localparam int CB   = 3;
  localparam int SMAX = 8;
  localparam int DLY  = 16;
  localparam int PER  = 4;
  localparam int DIV  = 8;
  localparam int CMAX = 1 << CB;

  typedef logic [30:0] vec_t;
  localparam vec_t RST_VEC = {3'b100, 4'd1, 9'h1FF, 9'h000, 4'h0, 1'b1, 1'b0};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        inValid = 1'b0;
  logic [3:0]  inCode = 4'h0;
  logic [2:0]  userNum;
  logic [3:0]  charSize;
  logic [8:0]  charRGB;
  logic [8:0]  bgRGB;
  logic [3:0]  charOffset;
  logic        flashClk;
  logic        cmdAck;

  cmd_decoder #(
    .CH_BITS(CB), .SIZE_MAX(SMAX), .REPEAT_DLY(DLY), .REPEAT_PER(PER), .FLASH_DIV(DIV)
  ) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inCode(inCode),
    .userNum(userNum), .charSize(charSize), .charRGB(charRGB), .bgRGB(bgRGB),
    .charOffset(charOffset), .flashClk(flashClk), .cmdAck(cmdAck)
  );

  always #5 clock = ~clock;

  vec_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  // Behavioural model state
  int m_user, m_size, m_off, m_flash, m_ack, m_tgt, m_fen, m_age, m_held;
  int m_prev_v, m_prev_c;
  int m_fg[3];
  int m_bg[3];

  function automatic vec_t dut_vec();
    return {userNum, charSize, charRGB, bgRGB, charOffset, flashClk, cmdAck};
  endfunction

  function automatic vec_t model_vec();
    return {3'(m_user), 4'(m_size), 3'(m_fg[0]), 3'(m_fg[1]), 3'(m_fg[2]),
            3'(m_bg[0]), 3'(m_bg[1]), 3'(m_bg[2]), 4'(m_off), 1'(m_flash), 1'(m_ack)};
  endfunction

  task automatic model_step(input logic r, input logic v, input logic [3:0] c);
    bit fire;
    int code;
    if (r) begin
      m_user = 4; m_size = 1; m_off = 0; m_flash = 1; m_ack = 0;
      m_tgt = 0; m_fen = 0; m_age = 0; m_held = 0; m_prev_v = 0; m_prev_c = 0;
      for (int k = 0; k < 3; k++) begin
        m_fg[k] = CMAX - 1;
        m_bg[k] = 0;
      end
      return;
    end
    fire = 0;
    code = int'(c);
    if (v) begin
      if (m_prev_v == 0 || code != m_prev_c) begin
        fire = 1;
        m_held = 0;
      end else begin
        m_held++;
        if (code >= 4 && code <= 12 && m_held >= DLY && ((m_held - DLY) % PER) == 0) fire = 1;
      end
    end else begin
      m_held = 0;
    end
    m_prev_v = int'(v);
    m_prev_c = code;
    m_off = 0;
    m_ack = int'(fire);
    if (m_fen != 0) m_age++;
    if (fire) begin
      case (code)
        0, 1, 2, 3: m_user = code;
        4, 5, 6: begin
          if (m_tgt != 0) m_bg[code-4] = (m_bg[code-4] + 1) % CMAX;
          else            m_fg[code-4] = (m_fg[code-4] + 1) % CMAX;
        end
        7, 8, 9, 10: m_off = 1 << (code - 7);
        11: if (m_size < SMAX) m_size++;
        12: if (m_size > 1) m_size--;
        13: m_tgt = 1 - m_tgt;
        14: begin
          m_fen = 1 - m_fen;
          m_age = 0;
        end
        default: begin
          for (int k = 0; k < 3; k++) begin
            m_fg[k] = CMAX - 1;
            m_bg[k] = 0;
          end
        end
      endcase
    end
    m_flash = (m_fen != 0) ? int'(((m_age / DIV) % 2) == 0) : 1;
  endtask

  // Drive one cycle of inputs, queue the model's expectation, advance past the edge
  task automatic drive(input logic r, input logic v, input logic [3:0] c);
    reset = r;
    inValid = v;
    inCode = c;
    model_step(r, v, c);
    exp_q.push_back(model_vec());
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    vec_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 4'h5);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e) $display("FAIL reset_sb: got %h expected %h", dut_vec(), e);
      else n_pass++;
      n_chk++;
      if (dut_vec() !== RST_VEC) $display("FAIL reset_values: got %h expected %h", dut_vec(), RST_VEC);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 4'h0);
    e = exp_q.pop_front();
    n_chk++;
    if (dut_vec() !== e) $display("FAIL reset_idle_sb: got %h expected %h", dut_vec(), e);
    else n_pass++;
  endtask

  task automatic test_user_select();
    vec_t e;
    drive(1'b0, 1'b1, 4'h2);
    e = exp_q.pop_front();
    n_chk++;
    if (dut_vec() !== e) $display("FAIL user_sb: got %h expected %h", dut_vec(), e);
    else n_pass++;
    n_chk++;
    if ({userNum, cmdAck} !== {3'b010, 1'b1}) $display("FAIL user_sel: got user=%b ack=%b expected user=010 ack=1", userNum, cmdAck);
    else n_pass++;
    drive(1'b0, 1'b0, 4'h0);
    e = exp_q.pop_front();
    n_chk++;
    if (dut_vec() !== e) $display("FAIL user_idle_sb: got %h expected %h", dut_vec(), e);
    else n_pass++;
    n_chk++;
    if (cmdAck !== 1'b0) $display("FAIL user_ack_single: got %b expected 0", cmdAck);
    else n_pass++;
  endtask

  task automatic test_colour_wrap();
    vec_t e;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 4'h4);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e) $display("FAIL wrap_sb press %0d: got %h expected %h", i, dut_vec(), e);
      else n_pass++;
      if (i == 0) begin
        n_chk++;
        if (charRGB[8:6] !== 3'd0) $display("FAIL wrap_first: got R=%0d expected 0", charRGB[8:6]);
        else n_pass++;
      end
      drive(1'b0, 1'b0, 4'h0);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e) $display("FAIL wrap_idle_sb %0d: got %h expected %h", i, dut_vec(), e);
      else n_pass++;
    end
    n_chk++;
    if ({charRGB, bgRGB} !== {9'b000_111_111, 9'h000}) $display("FAIL wrap_final: got fg=%h bg=%h expected fg=03f bg=000", charRGB, bgRGB);
    else n_pass++;
  endtask

  task automatic test_hold_repeat();
    vec_t e;
    logic exp_ack;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 4'hB);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e) $display("FAIL repeat_sb cycle %0d: got %h expected %h", i, dut_vec(), e);
      else n_pass++;
      exp_ack = (i == 0) || (i >= DLY && ((i - DLY) % PER) == 0);
      n_chk++;
      if (cmdAck !== exp_ack) $display("FAIL repeat_ack cycle %0d: got %b expected %b", i, cmdAck, exp_ack);
      else n_pass++;
    end
    n_chk++;
    if (charSize !== 4'd8) $display("FAIL repeat_size: got %0d expected 8", charSize);
    else n_pass++;
    drive(1'b0, 1'b0, 4'h0);
    e = exp_q.pop_front();
    n_chk++;
    if (dut_vec() !== e) $display("FAIL repeat_idle_sb: got %h expected %h", dut_vec(), e);
    else n_pass++;
  endtask

  task automatic test_target_swap();
    vec_t e;
    logic [3:0] seq [4];
    seq = '{4'hD, 4'h6, 4'h6, 4'hF};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, seq[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e) $display("FAIL target_sb step %0d: got %h expected %h", i, dut_vec(), e);
      else n_pass++;
      if (i == 2) begin
        n_chk++;
        if (bgRGB !== 9'h002) $display("FAIL target_bg_blue: got %h expected 002", bgRGB);
        else n_pass++;
      end
      drive(1'b0, 1'b0, 4'h0);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e) $display("FAIL target_idle_sb %0d: got %h expected %h", i, dut_vec(), e);
      else n_pass++;
    end
    n_chk++;
    if ({charRGB, bgRGB} !== {9'h1FF, 9'h000}) $display("FAIL target_white: got fg=%h bg=%h expected fg=1ff bg=000", charRGB, bgRGB);
    else n_pass++;
  endtask

  task automatic test_flash();
    vec_t e;
    logic exp_f;
    drive(1'b0, 1'b1, 4'hE);
    e = exp_q.pop_front();
    n_chk++;
    if (dut_vec() !== e) $display("FAIL flash_on_sb: got %h expected %h", dut_vec(), e);
    else n_pass++;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 1'b0, 4'h0);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e) $display("FAIL flash_sb cycle %0d: got %h expected %h", i, dut_vec(), e);
      else n_pass++;
      exp_f = ((i / DIV) % 2) == 0;
      n_chk++;
      if (flashClk !== exp_f) $display("FAIL flash_phase cycle %0d: got %b expected %b", i, flashClk, exp_f);
      else n_pass++;
    end
    drive(1'b0, 1'b1, 4'hE);
    e = exp_q.pop_front();
    n_chk++;
    if (flashClk !== 1'b1 || dut_vec() !== e) $display("FAIL flash_off: got %h expected %h", dut_vec(), e);
    else n_pass++;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 4'h0);
      e = exp_q.pop_front();
      n_chk++;
      if (flashClk !== 1'b1 || dut_vec() !== e) $display("FAIL flash_stays_on %0d: got %h expected %h", i, dut_vec(), e);
      else n_pass++;
    end
  endtask

  task automatic test_move_reset();
    vec_t e;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 4'h9);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e || charOffset !== ((i == 0) ? 4'b0100 : 4'b0000))
        $display("FAIL move_down cycle %0d: got off=%b vec=%h expected vec=%h", i, charOffset, dut_vec(), e);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 4'hA);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e || charOffset !== ((i == 0) ? 4'b1000 : 4'b0000))
        $display("FAIL move_right cycle %0d: got off=%b vec=%h expected vec=%h", i, charOffset, dut_vec(), e);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 4'hA);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== RST_VEC || dut_vec() !== e) $display("FAIL move_in_reset %0d: got %h expected %h", i, dut_vec(), RST_VEC);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'hA);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e || {charOffset, cmdAck} !== ((i == 0) ? 5'b1000_1 : 5'b0000_0))
        $display("FAIL move_after_reset cycle %0d: got off=%b ack=%b vec=%h expected vec=%h", i, charOffset, cmdAck, dut_vec(), e);
      else n_pass++;
    end
    drive(1'b0, 1'b0, 4'h0);
    e = exp_q.pop_front();
    n_chk++;
    if (dut_vec() !== e) $display("FAIL move_idle_sb: got %h expected %h", dut_vec(), e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    vec_t e;
    logic [3:0] seq [12];
    seq = '{4'hB, 4'hB, 4'h1, 4'h7, 4'h2, 4'hC, 4'h0, 4'h8, 4'h3, 4'hD, 4'h5, 4'hD};
    // first B ramps size to the ceiling; the rest change every cycle
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 4'hB);
      drive(1'b0, 1'b0, 4'h0);
      e = exp_q.pop_front();
      e = exp_q.pop_front();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, seq[i]);
      e = exp_q.pop_front();
      n_chk++;
      if (dut_vec() !== e) $display("FAIL b2b_sb step %0d: got %h expected %h", i, dut_vec(), e);
      else n_pass++;
      if (i == 0) begin
        n_chk++;
        if ({charSize, cmdAck} !== {4'd8, 1'b1}) $display("FAIL b2b_size_sat: got size=%0d ack=%b expected size=8 ack=1", charSize, cmdAck);
        else n_pass++;
      end
    end
    drive(1'b0, 1'b0, 4'h0);
    e = exp_q.pop_front();
    n_chk++;
    if (dut_vec() !== e) $display("FAIL b2b_idle_sb: got %h expected %h", dut_vec(), e);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_user_select();
    test_colour_wrap();
    test_hold_repeat();
    test_target_swap();
    test_flash();
    test_move_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
